// File: rtl/stream_harness_gen_pkg.sv
// Shared types, state encodings and the Galois LFSR step used by the stream harness.
package stream_harness_gen_pkg;

  typedef logic [1:0] harness_state_e;

  localparam harness_state_e StIdle = 2'd0;
  localparam harness_state_e StRun  = 2'd1;
  localparam harness_state_e StDone = 2'd2;
  localparam harness_state_e StFail = 2'd3;

  // Encoding 3 is a second spelling of incrementing mode.
  typedef enum logic [1:0] {
    ModeIncr  = 2'd0,
    ModeConst = 2'd1,
    ModeLfsr  = 2'd2,
    ModeIncr2 = 2'd3
  } src_mode_e;

  localparam int unsigned LfsrMaxW = 64;

  // Right-shifting Galois step; callers zero-extend narrower words and truncate the result.
  function automatic logic [LfsrMaxW-1:0] lfsr_step(input logic [LfsrMaxW-1:0] value,
                                                   input logic [LfsrMaxW-1:0] taps);
    lfsr_step = (value >> 1) ^ (value[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/stream_harness_gen_src_chan.sv
// One source channel: LANES registered words advancing by increment, hold or LFSR step.
module stream_harness_gen_src_chan
  import stream_harness_gen_pkg::*;
#(
  parameter int unsigned        LANES     = 1,
  parameter int unsigned        DATA_W    = 16,
  parameter logic [DATA_W-1:0]  LFSR_TAPS = 16'hB400
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    advance,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       seed,
  output logic [LANES*DATA_W-1:0] data
);

  logic [1:0]              mode_q;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LfsrMaxW-1:0]     step;

  always_comb begin
    data_d = data_q;
    step   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (load) begin
        if (mode == ModeConst || mode == ModeLfsr) begin
          data_d[l*DATA_W +: DATA_W] = seed;
        end else begin
          data_d[l*DATA_W +: DATA_W] = seed + DATA_W'(l);
        end
      end else if (advance) begin
        unique case (mode_q)
          ModeConst: data_d[l*DATA_W +: DATA_W] = data_q[l*DATA_W +: DATA_W];
          ModeLfsr: begin
            step = lfsr_step(LfsrMaxW'(data_q[l*DATA_W +: DATA_W]), LfsrMaxW'(LFSR_TAPS));
            data_d[l*DATA_W +: DATA_W] = step[DATA_W-1:0];
          end
          default: data_d[l*DATA_W +: DATA_W] = data_q[l*DATA_W +: DATA_W] + DATA_W'(LANES);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= ModeIncr;
    end else if (clear) begin
      data_q <= '0;
      mode_q <= ModeIncr;
    end else begin
      data_q <= data_d;
      if (load) mode_q <= mode;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/stream_harness_gen.sv
// Stimulus/checker harness: NUM_IN pattern sources, NUM_OUT incrementing sink checkers,
// watchdog and first-mismatch capture around an accelerator under test.
module stream_harness_gen
  import stream_harness_gen_pkg::*;
#(
  parameter int unsigned       NUM_IN    = 9,
  parameter int unsigned       NUM_OUT   = 8,
  parameter int unsigned       LANES     = 1,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       CNT_W     = 32,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400,
  parameter int unsigned       TIMEOUT   = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              start,
  input  logic [2*NUM_IN-1:0]               src_mode,
  input  logic [NUM_IN*DATA_W-1:0]          src_seed,
  input  logic [NUM_OUT*DATA_W-1:0]         chk_base,
  input  logic [CNT_W-1:0]                  chk_count,
  input  logic [NUM_IN-1:0]                 in_rd_en,
  output logic [NUM_IN*LANES*DATA_W-1:0]    in_data,
  input  logic [NUM_OUT-1:0]                out_valid,
  input  logic [NUM_OUT*LANES*DATA_W-1:0]   out_data,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              timeout,
  output logic [$clog2(NUM_OUT):0]          err_chan,
  output logic [CNT_W-1:0]                  err_index,
  output logic [DATA_W-1:0]                 err_got,
  output logic [DATA_W-1:0]                 err_exp
);

  localparam int unsigned ChanW = $clog2(NUM_OUT) + 1;
  localparam int unsigned WdW   = $clog2(TIMEOUT + 1);

  harness_state_e state_q, state_d;
  logic           run, load;

  assign run  = (state_q == StRun);
  assign load = start && (state_q == StIdle);

  for (genvar c = 0; c < NUM_IN; c++) begin : g_src
    stream_harness_gen_src_chan #(
      .LANES     (LANES),
      .DATA_W    (DATA_W),
      .LFSR_TAPS (LFSR_TAPS)
    ) u_src (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .load    (load),
      .advance (in_rd_en[c] && run),
      .mode    (src_mode[2*c +: 2]),
      .seed    (src_seed[c*DATA_W +: DATA_W]),
      .data    (in_data[c*LANES*DATA_W +: LANES*DATA_W])
    );
  end

  logic [NUM_OUT*LANES*DATA_W-1:0] exp_q, exp_d;
  logic [NUM_OUT*CNT_W-1:0]        cnt_q, cnt_d;
  logic [WdW-1:0]                  wd_q, wd_d;
  logic                            error_q;
  logic [ChanW-1:0]                err_chan_q;
  logic [CNT_W-1:0]                err_index_q;
  logic [DATA_W-1:0]               err_got_q, err_exp_q;

  logic              all_done, mis_any, ch_mis;
  logic [ChanW-1:0]  mis_chan;
  logic [CNT_W-1:0]  mis_index, cnt_c;
  logic [DATA_W-1:0] mis_got, mis_exp;
  int unsigned       lane_sel;

  // Channels are scanned low to high so the first one flagged wins the capture.
  always_comb begin
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    all_done  = 1'b1;
    mis_any   = 1'b0;
    mis_chan  = '0;
    mis_index = '0;
    mis_got   = '0;
    mis_exp   = '0;
    ch_mis    = 1'b0;
    lane_sel  = 0;
    cnt_c     = '0;
    for (int c = 0; c < NUM_OUT; c++) begin
      cnt_c    = cnt_q[c*CNT_W +: CNT_W];
      ch_mis   = 1'b0;
      lane_sel = 0;
      if (cnt_c != chk_count) all_done = 1'b0;
      if (load) begin
        cnt_d[c*CNT_W +: CNT_W] = '0;
        for (int l = 0; l < LANES; l++) begin
          exp_d[(c*LANES+l)*DATA_W +: DATA_W] = chk_base[c*DATA_W +: DATA_W] + DATA_W'(l);
        end
      end else if (run && out_valid[c]) begin
        ch_mis = (cnt_c == chk_count);
        for (int l = LANES - 1; l >= 0; l--) begin
          if (out_data[(c*LANES+l)*DATA_W +: DATA_W] != exp_q[(c*LANES+l)*DATA_W +: DATA_W]) begin
            ch_mis   = 1'b1;
            lane_sel = l;
          end
        end
        if (ch_mis && !mis_any) begin
          mis_any   = 1'b1;
          mis_chan  = ChanW'(c);
          mis_index = cnt_c;
          mis_got   = out_data[(c*LANES+lane_sel)*DATA_W +: DATA_W];
          mis_exp   = exp_q[(c*LANES+lane_sel)*DATA_W +: DATA_W];
        end
        // A channel that already met its quota holds its expectation and count.
        if (cnt_c != chk_count) begin
          for (int l = 0; l < LANES; l++) begin
            exp_d[(c*LANES+l)*DATA_W +: DATA_W] =
              exp_q[(c*LANES+l)*DATA_W +: DATA_W] + DATA_W'(LANES);
          end
          if (cnt_c != {CNT_W{1'b1}}) cnt_d[c*CNT_W +: CNT_W] = cnt_c + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (load) begin
      wd_d = '0;
    end else if (run) begin
      if (|out_valid)                  wd_d = '0;
      else if (wd_q != WdW'(TIMEOUT)) wd_d = wd_q + WdW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (all_done)                   state_d = StDone;
        else if (wd_q == WdW'(TIMEOUT)) state_d = StFail;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      error_q     <= 1'b0;
      err_chan_q  <= '0;
      err_index_q <= '0;
      err_got_q   <= '0;
      err_exp_q   <= '0;
    end else if (flush) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      error_q     <= 1'b0;
      err_chan_q  <= '0;
      err_index_q <= '0;
      err_got_q   <= '0;
      err_exp_q   <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      if (mis_any && !error_q) begin
        error_q     <= 1'b1;
        err_chan_q  <= mis_chan;
        err_index_q <= mis_index;
        err_got_q   <= mis_got;
        err_exp_q   <= mis_exp;
      end
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign timeout   = (state_q == StFail);
  assign error     = error_q;
  assign err_chan  = err_chan_q;
  assign err_index = err_index_q;
  assign err_got   = err_got_q;
  assign err_exp   = err_exp_q;

endmodule

// File: tb/tb_stream_harness_gen.sv
// Self-checking bench for stream_harness_gen: table-driven source vectors, random loopback
// against a behavioural source model, and hand-written error/timeout/reset sequences.
module tb_stream_harness_gen;

  localparam int unsigned NUM_IN  = 9;
  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 32;
  localparam logic [15:0] TAPS    = 16'hB400;

  logic                            clk, rst, flush, start;
  logic [2*NUM_IN-1:0]             src_mode;
  logic [NUM_IN*DATA_W-1:0]        src_seed;
  logic [NUM_OUT*DATA_W-1:0]       chk_base;
  logic [CNT_W-1:0]                chk_count;
  logic [NUM_IN-1:0]               in_rd_en;
  logic [NUM_IN*LANES*DATA_W-1:0]  in_data;
  logic [NUM_OUT-1:0]              out_valid;
  logic [NUM_OUT*LANES*DATA_W-1:0] out_data, corrupt_mask;
  logic                            loop_en;
  logic                            busy, done, error, timeout;
  logic [3:0]                      err_chan;
  logic [CNT_W-1:0]                err_index;
  logic [DATA_W-1:0]               err_got, err_exp;

  assign out_data = (loop_en ? in_data[NUM_OUT*LANES*DATA_W-1:0] : '0) ^ corrupt_mask;

  stream_harness_gen #(
    .NUM_IN (NUM_IN), .NUM_OUT (NUM_OUT), .LANES (LANES), .DATA_W (DATA_W), .CNT_W (CNT_W),
    .LFSR_TAPS (TAPS), .TIMEOUT (4096)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush), .start (start),
    .src_mode (src_mode), .src_seed (src_seed), .chk_base (chk_base), .chk_count (chk_count),
    .in_rd_en (in_rd_en), .in_data (in_data), .out_valid (out_valid), .out_data (out_data),
    .busy (busy), .done (done), .error (error), .timeout (timeout),
    .err_chan (err_chan), .err_index (err_index), .err_got (err_got), .err_exp (err_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural source model: one value per channel per lane.
  int          m_mode [NUM_IN];
  logic [15:0] m_val  [NUM_IN][LANES];
  bit          m_run;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int x = int'(v);
    return 16'((x / 2) ^ ((x % 2) == 1 ? int'(TAPS) : 0));
  endfunction

  task automatic model_start();
    for (int c = 0; c < NUM_IN; c++) begin
      m_mode[c] = int'(src_mode[2*c +: 2]);
      for (int l = 0; l < LANES; l++) begin
        if (m_mode[c] == 1 || m_mode[c] == 2) m_val[c][l] = src_seed[c*16 +: 16];
        else m_val[c][l] = 16'(int'(src_seed[c*16 +: 16]) + l);
      end
    end
    m_run = 1'b1;
  endtask

  task automatic model_step(input logic [NUM_IN-1:0] rd);
    if (!m_run) return;
    for (int c = 0; c < NUM_IN; c++) begin
      if (rd[c]) begin
        for (int l = 0; l < LANES; l++) begin
          if (m_mode[c] == 2)      m_val[c][l] = lfsr_next(m_val[c][l]);
          else if (m_mode[c] != 1) m_val[c][l] = 16'(int'(m_val[c][l]) + LANES);
        end
      end
    end
  endtask

  task automatic check_src(input string tag);
    logic [63:0] e;
    for (int c = 0; c < NUM_IN; c++) begin
      for (int l = 0; l < LANES; l++) e[l*16 +: 16] = m_val[c][l];
      check($sformatf("%s_src%0d", tag, c), 64'(in_data[c*64 +: 64]), e);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_run = 1'b0;
  endtask

  typedef struct {
    int          chan;
    logic [1:0]  mode;
    logic [15:0] seed;
    int          reads;
    logic [15:0] exp0;
    logic [15:0] exp3;
  } src_vec_t;

  src_vec_t tbl [6];

  initial begin
    #2ms;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_IN-1:0] rd;
    int                m_cnt [NUM_OUT];
    bit                all16;
    int                n;
    logic [15:0]       seed2;

    tbl[0] = '{0, 2'd0, 16'h0005, 3, 16'h0011, 16'h0014};
    tbl[1] = '{1, 2'd0, 16'h0000, 1, 16'h0004, 16'h0007};
    tbl[2] = '{2, 2'd1, 16'h0009, 2, 16'h0009, 16'h0009};
    tbl[3] = '{3, 2'd2, 16'h0001, 2, 16'h5A00, 16'h5A00};
    tbl[4] = '{4, 2'd3, 16'hFFFE, 1, 16'h0002, 16'h0005};
    tbl[5] = '{5, 2'd2, 16'hB400, 1, 16'h5A00, 16'h5A00};

    rst = 1'b1; flush = 1'b0; start = 1'b0; src_mode = '0; src_seed = '0; chk_base = '0;
    chk_count = '0; in_rd_en = '0; out_valid = '0; corrupt_mask = '0; loop_en = 1'b0;
    m_run = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_timeout", 64'(timeout), 0);
    check("rst_err_chan", 64'(err_chan), 0);
    check("rst_err_index", 64'(err_index), 0);
    check("rst_in_data_nz", 64'(|in_data), 0);

    // Read enables in IDLE are ignored
    src_seed = '1;
    in_rd_en = '1;
    tick(); tick();
    in_rd_en = '0;
    check("idle_rd_ignored", 64'(|in_data), 0);

    // Table-driven source vectors, all channels started together
    src_mode = '0; src_seed = '0; chk_count = 100;
    foreach (tbl[i]) begin
      src_mode[tbl[i].chan*2 +: 2]  = tbl[i].mode;
      src_seed[tbl[i].chan*16 +: 16] = tbl[i].seed;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    check("tbl_busy", 64'(busy), 1);
    check("tbl_incr_seed_l0", 64'(in_data[15:0]), 64'h5);
    check("tbl_incr_seed_l1", 64'(in_data[31:16]), 64'h6);
    check_src("tbl_start");
    for (int t = 0; t < 3; t++) begin
      rd = '0;
      foreach (tbl[i]) if (t < tbl[i].reads) rd[tbl[i].chan] = 1'b1;
      in_rd_en = rd;
      tick();
      model_step(rd);
    end
    in_rd_en = '0;
    tick();
    foreach (tbl[i]) begin
      check($sformatf("tbl%0d_lane0", i), 64'(in_data[(tbl[i].chan*4)*16 +: 16]), 64'(tbl[i].exp0));
      check($sformatf("tbl%0d_lane3", i), 64'(in_data[(tbl[i].chan*4+3)*16 +: 16]),
            64'(tbl[i].exp3));
    end
    check_src("tbl_end");
    do_flush();
    check("flush_busy", 64'(busy), 0);
    check("flush_in_data_nz", 64'(|in_data), 0);

    // Random loopback with gaps: every sink must finish with no error
    for (int c = 0; c < NUM_IN; c++) begin
      src_mode[2*c +: 2] = (c < NUM_OUT) ? (($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0)
                                         : 2'($urandom_range(0, 3));
      src_seed[c*16 +: 16] = 16'($urandom);
      if (c < NUM_OUT) chk_base[c*16 +: 16] = src_seed[c*16 +: 16];
    end
    chk_count = 16;
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    foreach (m_cnt[c]) m_cnt[c] = 0;
    all16 = 1'b0;
    for (int cyc = 0; cyc < 300 && !all16; cyc++) begin
      rd = NUM_IN'($urandom);
      for (int c = 0; c < NUM_OUT; c++) if (m_cnt[c] == 16) rd[c] = 1'b0;
      in_rd_en  = rd;
      out_valid = rd[NUM_OUT-1:0];
      check_src($sformatf("rnd%0d", cyc));
      tick();
      model_step(rd);
      all16 = 1'b1;
      for (int c = 0; c < NUM_OUT; c++) begin
        if (rd[c]) m_cnt[c]++;
        if (m_cnt[c] != 16) all16 = 1'b0;
      end
    end
    in_rd_en = '0; out_valid = '0;
    check("rnd_all_transfers", 64'(all16), 1);
    check("rnd_done_not_yet", 64'(done), 0);
    check("rnd_busy_last", 64'(busy), 1);
    tick();
    check("rnd_done", 64'(done), 1);
    check("rnd_busy_after", 64'(busy), 0);
    check("rnd_error", 64'(error), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_ignored", 64'(done), 1);
    do_flush();

    // Two channels corrupted on the same transfer: lowest channel, lowest lane captured
    src_mode = '0;
    for (int c = 0; c < NUM_IN; c++) src_seed[c*16 +: 16] = 16'($urandom);
    for (int c = 0; c < NUM_OUT; c++) chk_base[c*16 +: 16] = src_seed[c*16 +: 16];
    seed2 = src_seed[2*16 +: 16];
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    for (int t = 0; t < 16; t++) begin
      in_rd_en = '1; out_valid = '1;
      if (t == 7) begin
        corrupt_mask[(2*4+1)*16 +: 16] = 16'h0010;
        corrupt_mask[(2*4+3)*16 +: 16] = 16'h0010;
        corrupt_mask[(5*4)*16 +: 16]   = 16'h0010;
        check("err_before_edge", 64'(error), 0);
      end
      tick();
      model_step(in_rd_en);
      corrupt_mask = '0;
      if (t == 7) begin
        check("err_set", 64'(error), 1);
        check("err_chan", 64'(err_chan), 2);
        check("err_index", 64'(err_index), 7);
        check("err_exp", 64'(err_exp), 64'(16'(seed2 + 16'd1 + 16'(7 * LANES))));
        check("err_got", 64'(err_got), 64'(16'(seed2 + 16'd1 + 16'(7 * LANES)) ^ 16'h0010));
      end
    end
    in_rd_en = '0; out_valid = '0;
    check("err_done_not_yet", 64'(done), 0);
    tick();
    check("err_done_at_17", 64'(done), 1);
    check("err_sticky", 64'(error), 1);
    check("err_chan_held", 64'(err_chan), 2);
    do_flush();
    check("flush_error", 64'(error), 0);
    check("flush_err_chan", 64'(err_chan), 0);
    check("flush_err_index", 64'(err_index), 0);
    check("flush_err_got", 64'(err_got), 0);
    check("flush_done", 64'(done), 0);

    // Extra valid on a channel already at its quota
    chk_count = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_rd_en = 9'b1; out_valid = 8'b1;
      tick();
      if (t == 1) check("over_no_err_yet", 64'(error), 0);
    end
    in_rd_en = '0; out_valid = '0;
    check("over_error", 64'(error), 1);
    check("over_err_chan", 64'(err_chan), 0);
    check("over_err_index", 64'(err_index), 2);
    check("over_busy", 64'(busy), 1);
    do_flush();

    // Asynchronous reset mid-run clears without a clock edge
    chk_count = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_rd_en = '1;
    tick();
    in_rd_en = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_in_data_nz", 64'(|in_data), 0);
    tick();
    rst = 1'b0;

    // Watchdog: no output activity until timeout
    chk_count = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!timeout && n < 5000) begin
      tick();
      n++;
    end
    check("wd_timeout", 64'(timeout), 1);
    check("wd_cycles_in_range", 64'(n >= 4096 && n <= 4098), 1);
    check("wd_busy", 64'(busy), 0);
    check("wd_done", 64'(done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fail_start_ignored", 64'(timeout), 1);
    do_flush();
    check("wd_flush_timeout", 64'(timeout), 0);
    check("wd_flush_busy", 64'(busy), 0);
    check("wd_flush_error", 64'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
